if_prefetch_queue: RTL

//  Parametrised instruction-fetch front end; successor to the fixed PC register + single IF/ID latch.

---
 rtl/if_prefetch_queue_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/if_prefetch_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared types for the fetch front end.
// PC width, queued fetch entry layout and an alignment helper.
package if_prefetch_queue_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with async reset and flush.
// A pop frees the slot a same-cycle push uses, so push+pop works when full.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and count next state; flush wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential prefetcher with an instruction queue.
// Credit-limited imem issue; redirects flush and squash in-flight words.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int unsigned    DEPTH           = 4,
  parameter int unsigned    MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  localparam int unsigned   OCW = $clog2(DEPTH + 1),
  localparam int unsigned   OSW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [OCW-1:0]  occupancy
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OSW-1:0]  outst_q, outst_d;
  logic [OSW-1:0]  discard_q, discard_d;

  logic            accept;
  logic            rsp_keep;
  logic            id_pop;
  logic            room_ok;
  logic            credit_ok;
  logic [31:0]     live_w;

  logic [XLEN-1:0] inflight_pc;
  logic            if_full, if_empty;
  logic [OSW-1:0]  if_count;

  fetch_entry_t    q_in, q_head;
  logic            q_full, q_empty;

  logic            if_unused;

  // Queued entries plus live (non-discarded) requests must fit the queue.
  assign live_w    = 32'(occupancy) + 32'(outst_q) - 32'(discard_q);
  assign credit_ok = live_w < 32'(DEPTH);
  assign room_ok   = 32'(outst_q) < 32'(MAX_OUTSTANDING);

  assign imem_req_valid = !rst && !redirect_valid
                        && room_ok && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (discard_q == '0)
                  && !redirect_valid;

  assign id_valid = !q_empty && !redirect_valid;
  assign id_pop   = id_valid && id_ready;
  assign id_pc    = q_head.pc;
  assign id_instr = q_head.instr;

  assign q_in.pc    = inflight_pc;
  assign q_in.instr = imem_rsp_data;

  assign if_unused = ^{if_full, if_empty, if_count};

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (imem_rsp_valid),
    .data_o  (inflight_pc),
    .full_o  (if_full),
    .empty_o (if_empty),
    .count_o (if_count)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_keep),
    .data_i  (q_in),
    .pop_i   (id_pop),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occupancy)
  );

  // Fetch PC, outstanding and discard next state; redirect dominates.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (accept && !imem_rsp_valid) begin
      outst_d = outst_q + 1'b1;
    end else if (!accept && imem_rsp_valid) begin
      outst_d = outst_q - 1'b1;
    end
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      discard_d  = outst_d;
    end else if (imem_rsp_valid && discard_q != '0) begin
      discard_d = discard_q - 1'b1;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  a_rsp_unrequested: assert property (
    @(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outst_q != '0)
  );

  a_queue_overflow: assert property (
    @(posedge clk) disable iff (rst)
    (rsp_keep && q_full) |-> id_pop
  );

endmodule
